reaction_timer: RTL

//  Timing front-end for the reaction-game FSM. Draws a pseudo-random wait from a free-running LFSR on start.

---
 rtl/game_pkg.sv | 20 ++
 rtl/lfsr16.sv | 19 +
 rtl/reaction_timer.sv | 96 +++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the reaction game: FSM state codes, millisecond width
// and the LFSR step function used by the timing front-end.
package game_pkg;

    localparam int MS_W = 16;

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_WAIT = 3'b001;
    localparam logic [2:0] ST_MEAS = 3'b011;
    localparam logic [2:0] ST_FAIL = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b111;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every clock regardless of the game state.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Timing front-end for the reaction game: random pre-wait, millisecond tick and
// reaction-time measurement with a sticky timeout flag.
module reaction_timer
    import game_pkg::*;
#(
    parameter int unsigned  TICK_DIV    = 100000,
    parameter int unsigned  RAND_MIN_MS = 1000,
    parameter logic [15:0]  RAND_MASK   = 16'h07FF,
    parameter int unsigned  TIMEOUT_MS  = 2000,
    parameter logic [15:0]  LFSR_SEED   = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      state,
    output logic            get_rand,
    output logic            time_out,
    output logic [MS_W-1:0] act_time
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [MS_W-1:0] MIN_WAIT   = MS_W'(RAND_MIN_MS);
    localparam logic [MS_W-1:0] LIMIT      = MS_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0] MS_MAX     = '1;

    logic [15:0]     lfsr_q;
    logic [2:0]      state_d;
    logic [PW-1:0]   presc;
    logic [MS_W-1:0] delay_cnt;
    logic [MS_W-1:0] target;
    logic            active;
    logic            entry;
    logic            tick;
    logic            launch;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Unknown state codes fall outside both the active set and the start condition
    assign active = (state == ST_WAIT) || (state == ST_MEAS);
    assign entry  = (state != state_d);
    assign tick   = active && !entry && (presc == PRESC_LAST);
    assign launch = start && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_d   <= ST_IDLE;
            presc     <= '0;
            delay_cnt <= '0;
            target    <= '0;
            act_time  <= '0;
            time_out  <= 1'b0;
            get_rand  <= 1'b0;
        end else begin
            state_d  <= state;
            get_rand <= 1'b0;

            if (launch) begin
                target    <= MIN_WAIT + (lfsr_q & RAND_MASK);
                act_time  <= '0;
                delay_cnt <= '0;
                time_out  <= 1'b0;
                presc     <= '0;
            end else if (active) begin
                if (entry || tick) begin
                    presc <= '0;
                end else begin
                    presc <= presc + PW'(1);
                end

                // Counter parks at target so the expiry pulse fires only once per round
                if ((state == ST_WAIT) && tick && (delay_cnt != target)) begin
                    delay_cnt <= delay_cnt + MS_W'(1);
                    get_rand  <= ((delay_cnt + MS_W'(1)) == target);
                end

                if (state == ST_MEAS) begin
                    if (tick && (act_time != MS_MAX)) begin
                        act_time <= act_time + MS_W'(1);
                    end
                    if (act_time >= LIMIT) begin
                        time_out <= 1'b1;
                    end
                end
            end else begin
                presc <= '0;
            end
        end
    end

endmodule
